// File: rtl/blinky_core.sv
// blinky_core: prescaled 4-LED pattern sequencer (COUNT/ROTATE/BOUNCE) with a debounced mode button.
// Define BLINKY_PWM_EN to turn led5 into a PWM "breathing" LED instead of a tick-rate toggle.
module blinky_core #(
    parameter int PRESCALE_W = 22,
    parameter int DEBOUNCE_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic mode_btn,
    output logic led1,
    output logic led2,
    output logic led3,
    output logic led4,
    output logic led5,
    output logic tick
);

    typedef enum logic [1:0] {
        ST_COUNT  = 2'd0,
        ST_ROTATE = 2'd1,
        ST_BOUNCE = 2'd2
    } state_t;

    localparam logic [PRESCALE_W-1:0] PRESC_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};
    localparam logic [DEBOUNCE_W-1:0] DB_ONE    = {{(DEBOUNCE_W-1){1'b0}}, 1'b1};

    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  tick_q, tick_d;
    logic                  sync1_q, sync1_d;
    logic                  sync2_q, sync2_d;
    logic [DEBOUNCE_W-1:0] db_cnt_q, db_cnt_d;
    logic                  stable_q, stable_d;
    logic                  mode_adv_q, mode_adv_d;
    state_t                state_q, state_d;
    logic [3:0]            pattern_q, pattern_d;
    logic                  dir_up_q, dir_up_d;
    logic                  led5_q, led5_d;

    // Prescaler: free-running, never disturbed by mode changes.
    always_comb begin
        presc_d = presc_q + PRESC_ONE;
        tick_d  = &presc_q;
    end

    always_comb begin
        sync1_d = mode_btn;
        sync2_d = sync1_q;
    end

    // A new level is accepted only after it has differed from the stable level
    // for 2^DEBOUNCE_W consecutive cycles; any return to the old level restarts the wait.
    always_comb begin
        db_cnt_d   = '0;
        stable_d   = stable_q;
        mode_adv_d = 1'b0;
        if (sync2_q != stable_q) begin
            if (&db_cnt_q) begin
                stable_d   = sync2_q;
                mode_adv_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_ONE;
            end
        end
    end

    // Mode FSM and pattern generator; a mode change takes priority over a tick step.
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        dir_up_d  = dir_up_q;
        if (mode_adv_q) begin
            case (state_q)
                ST_COUNT: begin
                    state_d   = ST_ROTATE;
                    pattern_d = 4'b0001;
                end
                ST_ROTATE: begin
                    state_d   = ST_BOUNCE;
                    pattern_d = 4'b0001;
                    dir_up_d  = 1'b1;
                end
                default: begin
                    state_d   = ST_COUNT;
                    pattern_d = 4'b0000;
                end
            endcase
        end else if (tick_q) begin
            case (state_q)
                ST_COUNT:  pattern_d = pattern_q + 4'd1;
                ST_ROTATE: pattern_d = {pattern_q[2:0], pattern_q[3]};
                default: begin
                    if (dir_up_q) begin
                        pattern_d = {pattern_q[2:0], 1'b0};
                        if (pattern_q[2]) begin
                            dir_up_d = 1'b0;
                        end
                    end else begin
                        pattern_d = {1'b0, pattern_q[3:1]};
                        if (pattern_q[1]) begin
                            dir_up_d = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef BLINKY_PWM_EN
    logic [3:0] pwm_cnt_q, pwm_cnt_d;
    logic [3:0] duty_q, duty_d;
    logic       duty_up_q, duty_up_d;

    // Duty walks a triangle 0..15..0, one step per tick.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 4'd1;
        duty_d    = duty_q;
        duty_up_d = duty_up_q;
        if (tick_q) begin
            if (duty_up_q) begin
                if (duty_q == 4'd15) begin
                    duty_d    = 4'd14;
                    duty_up_d = 1'b0;
                end else begin
                    duty_d = duty_q + 4'd1;
                end
            end else begin
                if (duty_q == 4'd0) begin
                    duty_d    = 4'd1;
                    duty_up_d = 1'b1;
                end else begin
                    duty_d = duty_q - 4'd1;
                end
            end
        end
        led5_d = (pwm_cnt_q < duty_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q <= 4'd0;
            duty_q    <= 4'd0;
            duty_up_q <= 1'b1;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            duty_q    <= duty_d;
            duty_up_q <= duty_up_d;
        end
    end
`else
    always_comb begin
        led5_d = led5_q ^ tick_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            tick_q     <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_cnt_q   <= '0;
            stable_q   <= 1'b0;
            mode_adv_q <= 1'b0;
            state_q    <= ST_COUNT;
            pattern_q  <= 4'b0000;
            dir_up_q   <= 1'b1;
            led5_q     <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_cnt_q   <= db_cnt_d;
            stable_q   <= stable_d;
            mode_adv_q <= mode_adv_d;
            state_q    <= state_d;
            pattern_q  <= pattern_d;
            dir_up_q   <= dir_up_d;
            led5_q     <= led5_d;
        end
    end

    assign led1 = pattern_q[0];
    assign led2 = pattern_q[1];
    assign led3 = pattern_q[2];
    assign led4 = pattern_q[3];
    assign led5 = led5_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_blinky_core.sv
// Testbench for blinky_core (PRESCALE_W=4, DEBOUNCE_W=3, default build without BLINKY_PWM_EN).
module tb_blinky_core;
    localparam int PW     = 4;
    localparam int DW     = 3;
    localparam int PERIOD = 1 << PW;
    localparam int DB_LEN = 1 << DW;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic mode_btn = 1'b0;
    logic led1, led2, led3, led4, led5, tick;

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;
    bit chk_en = 1'b0;

    blinky_core #(.PRESCALE_W(PW), .DEBOUNCE_W(DW)) dut (
        .clk(clk), .rst(rst), .mode_btn(mode_btn),
        .led1(led1), .led2(led2), .led3(led3), .led4(led4), .led5(led5), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_n = 0, m_mode = 0, m_phase = 0, m_pat = 0;
    bit m_led5 = 0, m_tick = 0, m_adv = 0, m_stable = 0, m_s1 = 0, m_s2 = 0;
    bit m_win[$];
    int bounce_pos[6] = '{0, 1, 2, 3, 2, 1};

    always @(posedge clk) begin : model
        bit s;
        bit flip;
        if (rst) begin
            m_n = 0; m_mode = 0; m_phase = 0; m_pat = 0;
            m_led5 = 0; m_tick = 0; m_adv = 0; m_stable = 0; m_s1 = 0; m_s2 = 0;
            m_win.delete();
        end else begin
            if (m_adv) begin
                m_mode  = (m_mode + 1) % 3;
                m_phase = 0;
                m_pat   = (m_mode == 0) ? 0 : 1;
            end else if (m_tick) begin
                case (m_mode)
                    0: m_pat = (m_pat + 1) % 16;
                    1: m_pat = (m_pat * 2) % 16 + m_pat / 8;
                    default: begin
                        m_phase = (m_phase + 1) % 6;
                        m_pat   = 1 << bounce_pos[m_phase];
                    end
                endcase
            end
            if (m_tick) m_led5 = !m_led5;
            m_n++;
            m_tick = (m_n % PERIOD == 0);
            s = m_s2; m_s2 = m_s1; m_s1 = mode_btn;
            m_win.push_back(s);
            if (m_win.size() > DB_LEN) void'(m_win.pop_front());
            m_adv = 0;
            flip = (m_win.size() == DB_LEN);
            foreach (m_win[k]) if (m_win[k] == m_stable) flip = 0;
            if (flip) begin
                m_stable = !m_stable;
                m_adv    = m_stable;
                m_win.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_leds", {led4, led3, led2, led1}, m_pat);
            check("model_led5", led5, m_led5);
            check("model_tick", tick, m_tick);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            ncyc++;
        end
    endtask

    task automatic press(input int exp_pat, input string nm);
        mode_btn = 1'b0;
        step(12);
        do step(1); while (ncyc % PERIOD != 1);
        mode_btn = 1'b1;
        step(12);
        check(nm, {led4, led3, led2, led1}, exp_pat);
        mode_btn = 1'b0;
    endtask

    typedef struct {
        bit btn;
        int cycles;
        int pat;
        bit l5;
        bit tk;
    } vec_t;

    vec_t tbl[11];
    int   bexp[7] = '{2, 4, 8, 4, 2, 1, 2};
    bit   l5_before;

    initial begin
        tbl[0]  = '{1'b0, 15, 0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1,  0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1,  1, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 5,  1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 10, 1, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 1,  2, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 11, 1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 9,  2, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 12, 4, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 16, 8, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 16, 1, 1'b0, 1'b0};

        rst = 1'b1;
        step(3);
        chk_en = 1'b1;
        check("rst_leds", {led4, led3, led2, led1}, 0);
        check("rst_led5", led5, 0);
        check("rst_tick", tick, 0);
        rst  = 1'b0;
        ncyc = 0;

        for (int i = 0; i < 11; i++) begin
            mode_btn = tbl[i].btn;
            step(tbl[i].cycles);
            check($sformatf("tbl%0d_leds", i), {led4, led3, led2, led1}, tbl[i].pat);
            check($sformatf("tbl%0d_led5", i), led5, tbl[i].l5);
            check($sformatf("tbl%0d_tick", i), tick, tbl[i].tk);
        end

        press(1, "enter_bounce");
        for (int i = 0; i < 7; i++) begin
            do step(1); while (ncyc % PERIOD != 1);
            check($sformatf("bounce%0d", i), {led4, led3, led2, led1}, bexp[i]);
        end
        do step(1); while (ncyc % PERIOD != 1);
        check("bounce_pre_rst", {led4, led3, led2, led1}, 4);

        rst = 1'b1;
        step(1);
        check("midrst_leds", {led4, led3, led2, led1}, 0);
        check("midrst_led5", led5, 0);
        check("midrst_tick", tick, 0);
        rst  = 1'b0;
        ncyc = 0;

        press(1, "post_rst_rotate");
        press(1, "post_rst_bounce");
        press(0, "back_to_count");

        mode_btn = 1'b0;
        step(12);
        do step(1); while (ncyc % PERIOD != 6);
        mode_btn = 1'b1;
        step(10);
        check("align_tick", tick, 1);
        l5_before = m_led5;
        step(1);
        check("align_pat", {led4, led3, led2, led1}, 1);
        check("align_led5", led5, !l5_before);
        mode_btn = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) mode_btn = ~mode_btn;
            rst = ($urandom_range(0, 599) == 0);
            step(1);
        end
        rst = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
